// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter.
//   arb_state_t : one-hot FSM encoding (idle / request / response)
//   OWN_INST, OWN_DATA : values of owner_data naming the granted requester
package mem_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    s_IDLE = 3'b001,
    s_REQ  = 3'b010,
    s_RSP  = 3'b100
  } arb_state_t;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

endpackage

// File: rtl/mem_bus_arbiter_grant.sv
// mem_arb_grant: combinational grant selection between the fetch and
// load/store requesters.
//   inst_valid, data_valid : requester valids
//   owner_data             : last granted requester (OWN_DATA / OWN_INST)
//   grant_inst, grant_data : at most one asserted
// Optional macro MEM_ARB_RR_EN: on contention grant the requester that was
// not granted last; otherwise the data requester has fixed priority.
module mem_arb_grant
  import mem_bus_arbiter_pkg::*;
(
  input  logic inst_valid,
  input  logic data_valid,
  input  logic owner_data,
  output logic grant_inst,
  output logic grant_data
);

`ifdef MEM_ARB_RR_EN
  logic last_was_data;
  assign last_was_data = (owner_data == OWN_DATA);

  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if (inst_valid && data_valid) begin
      grant_inst = last_was_data;
      grant_data = ~last_was_data;
    end else begin
      grant_inst = inst_valid;
      grant_data = data_valid;
    end
  end
`else
  logic unused_owner;
  assign unused_owner = owner_data;

  always_comb begin
    grant_data = data_valid;
    grant_inst = inst_valid & ~data_valid;
  end
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between instruction fetch and
// load/store. One outstanding transaction; the accepted request is
// registered and replayed downstream. Reads finish on the response
// handshake, writes finish on downstream request acceptance.
// Ports:
//   clk, rst                 : clock, async active-high reset
//   inst_req_* / inst_rsp_*  : fetch requester (read only)
//   data_req_* / data_rsp_*  : load/store requester
//   mem_*                    : downstream memory request/response
//   owner_data               : current/last grant (1 = data, 0 = inst)
//   busy                     : a transaction is in flight
// Optional macro MEM_ARB_RR_EN (see mem_arb_grant): alternate grant on
// contention instead of fixed data priority.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   inst_req_addr,
  input  logic                inst_req_valid,
  output logic                inst_req_ready,
  output logic [DATA_W-1:0]   inst_rsp_data,
  output logic                inst_rsp_valid,
  input  logic                inst_rsp_ready,
  input  logic [ADDR_W-1:0]   data_req_addr,
  input  logic                data_req_wen,
  input  logic [DATA_W-1:0]   data_req_wdata,
  input  logic [DATA_W/8-1:0] data_req_wstrb,
  input  logic                data_req_valid,
  output logic                data_req_ready,
  output logic [DATA_W-1:0]   data_rsp_data,
  output logic                data_rsp_valid,
  input  logic                data_rsp_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_rsp_valid,
  output logic                mem_rsp_ready,
  output logic                owner_data,
  output logic                busy
);

  arb_state_t state;
  logic       grant_inst;
  logic       grant_data;
  logic       in_idle;
  logic       in_req;
  logic       in_rsp;
  logic       owner_rsp_ready;

  mem_arb_grant u_grant (
    .inst_valid (inst_req_valid),
    .data_valid (data_req_valid),
    .owner_data (owner_data),
    .grant_inst (grant_inst),
    .grant_data (grant_data)
  );

  always_comb begin
    in_idle = (state == s_IDLE);
    in_req  = (state == s_REQ);
    in_rsp  = (state == s_RSP);
  end

  // Outputs decode the state register directly, so an asynchronous reset
  // drops them without waiting for a clock edge.
  always_comb begin
    inst_req_ready  = in_idle & grant_inst;
    data_req_ready  = in_idle & grant_data;
    mem_req_valid   = in_req;
    busy            = ~in_idle;
    owner_rsp_ready = (owner_data == OWN_DATA) ? data_rsp_ready : inst_rsp_ready;
    mem_rsp_ready   = in_rsp & owner_rsp_ready;
    inst_rsp_valid  = in_rsp & (owner_data == OWN_INST) & mem_rsp_valid;
    data_rsp_valid  = in_rsp & (owner_data == OWN_DATA) & mem_rsp_valid;
    inst_rsp_data   = mem_rdata;
    data_rsp_data   = mem_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= s_IDLE;
      mem_addr   <= '0;
      mem_wen    <= 1'b0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      owner_data <= OWN_INST;
    end else begin
      case (state)
        s_IDLE: begin
          // A grant is also the requester handshake: ready equals grant here.
          if (grant_data) begin
            mem_addr   <= data_req_addr;
            mem_wen    <= data_req_wen;
            mem_wdata  <= data_req_wdata;
            mem_wstrb  <= data_req_wstrb;
            owner_data <= OWN_DATA;
            state      <= s_REQ;
          end else if (grant_inst) begin
            mem_addr   <= inst_req_addr;
            mem_wen    <= 1'b0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            owner_data <= OWN_INST;
            state      <= s_REQ;
          end
        end
        s_REQ: begin
          if (mem_req_ready) begin
            state <= mem_wen ? s_IDLE : s_RSP;
          end
        end
        s_RSP: begin
          if (mem_rsp_valid && mem_rsp_ready) begin
            state <= s_IDLE;
          end
        end
        default: state <= s_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized scoreboard bench for mem_bus_arbiter.
module tb_mem_bus_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] inst_req_addr;
  logic          inst_req_valid;
  logic          inst_req_ready;
  logic [DW-1:0] inst_rsp_data;
  logic          inst_rsp_valid;
  logic          inst_rsp_ready;
  logic [AW-1:0] data_req_addr;
  logic          data_req_wen;
  logic [DW-1:0] data_req_wdata;
  logic [SW-1:0] data_req_wstrb;
  logic          data_req_valid;
  logic          data_req_ready;
  logic [DW-1:0] data_rsp_data;
  logic          data_rsp_valid;
  logic          data_rsp_ready;
  logic [AW-1:0] mem_addr;
  logic          mem_wen;
  logic [DW-1:0] mem_wdata;
  logic [SW-1:0] mem_wstrb;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [DW-1:0] mem_rdata;
  logic          mem_rsp_valid;
  logic          mem_rsp_ready;
  logic          owner_data;
  logic          busy;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .inst_req_addr(inst_req_addr), .inst_req_valid(inst_req_valid),
    .inst_req_ready(inst_req_ready), .inst_rsp_data(inst_rsp_data),
    .inst_rsp_valid(inst_rsp_valid), .inst_rsp_ready(inst_rsp_ready),
    .data_req_addr(data_req_addr), .data_req_wen(data_req_wen),
    .data_req_wdata(data_req_wdata), .data_req_wstrb(data_req_wstrb),
    .data_req_valid(data_req_valid), .data_req_ready(data_req_ready),
    .data_rsp_data(data_rsp_data), .data_rsp_valid(data_rsp_valid),
    .data_rsp_ready(data_rsp_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_rdata(mem_rdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
    .owner_data(owner_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic          wen;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          owner;
  } req_t;

  typedef struct {
    logic          owner;
    logic [DW-1:0] data;
  } rsp_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected control vector bits:
  // {inst_req_ready, data_req_ready, mem_req_valid, mem_rsp_ready,
  //  inst_rsp_valid, data_rsp_valid, busy, owner_data}
  logic [7:0] exp_ctl_q[$];
  req_t       exp_mem_q[$];
  rsp_t       exp_rsp_q[$];
  bit         mon_en = 1'b0;

  // Transaction-level reference: 0 = no transaction, 1 = waiting for the
  // memory to accept the request, 2 = waiting for read data.
  int   m_phase = 0;
  logic m_owner = 1'b0;
  req_t cur;
  bit   inst_taken = 1'b0;
  bit   data_taken = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Evaluates one cycle of the reference with the inputs now on the bus.
  task automatic model_cycle();
    logic [7:0] e;
    logic       gi, gd, rdy;
    req_t       r;
    rsp_t       s;
    e = '0;
    gi = 1'b0;
    gd = 1'b0;
    inst_taken = 1'b0;
    data_taken = 1'b0;
    e[0] = m_owner;
    e[1] = (m_phase != 0);
    case (m_phase)
      0: begin
`ifdef MEM_ARB_RR_EN
        if (inst_req_valid && data_req_valid) begin
          gd = !m_owner;
          gi = m_owner;
        end else begin
          gd = data_req_valid;
          gi = inst_req_valid;
        end
`else
        gd = data_req_valid;
        gi = inst_req_valid && !data_req_valid;
`endif
        e[7] = gi;
        e[6] = gd;
        if (gd) begin
          r.addr = data_req_addr; r.wen = data_req_wen; r.wdata = data_req_wdata;
          r.wstrb = data_req_wstrb; r.owner = 1'b1;
        end else begin
          r.addr = inst_req_addr; r.wen = 1'b0; r.wdata = '0;
          r.wstrb = '0; r.owner = 1'b0;
        end
        if (gd || gi) begin
          cur = r;
          exp_mem_q.push_back(r);
          m_owner = r.owner;
          m_phase = 1;
          inst_taken = gi;
          data_taken = gd;
        end
      end
      1: begin
        e[5] = 1'b1;
        if (mem_req_ready) m_phase = cur.wen ? 0 : 2;
      end
      default: begin
        rdy  = m_owner ? data_rsp_ready : inst_rsp_ready;
        e[4] = rdy;
        e[3] = !m_owner && mem_rsp_valid;
        e[2] = m_owner && mem_rsp_valid;
        if (mem_rsp_valid && rdy) begin
          s.owner = m_owner;
          s.data  = mem_rdata;
          exp_rsp_q.push_back(s);
          m_phase = 0;
        end
      end
    endcase
    exp_ctl_q.push_back(e);
  endtask

  task automatic drive_random();
    if (inst_taken) inst_req_valid = 1'b0;
    if (data_taken) data_req_valid = 1'b0;
    if (!inst_req_valid && $urandom_range(0, 2) == 0) begin
      inst_req_valid = 1'b1;
      inst_req_addr  = $urandom & 32'hFFFF_FFFC;
    end
    if (!data_req_valid && $urandom_range(0, 2) == 0) begin
      data_req_valid = 1'b1;
      data_req_addr  = $urandom;
      data_req_wen   = 1'($urandom_range(0, 1));
      data_req_wdata = $urandom;
      data_req_wstrb = 4'($urandom_range(0, 15));
    end
    mem_req_ready  = ($urandom_range(0, 3) != 0);
    mem_rsp_valid  = ($urandom_range(0, 2) != 0);
    mem_rdata      = $urandom;
    inst_rsp_ready = ($urandom_range(0, 3) != 0);
    data_rsp_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic drive_drain();
    inst_req_valid = 1'b0;
    data_req_valid = 1'b0;
    mem_req_ready  = 1'b1;
    mem_rsp_valid  = 1'b1;
    mem_rdata      = $urandom;
    inst_rsp_ready = 1'b1;
    data_rsp_ready = 1'b1;
  endtask

  // Monitor: compares every cycle's outputs and pops transactions as the
  // DUT presents them.
  always @(negedge clk) begin : monitor
    logic [7:0] a;
    req_t       r;
    rsp_t       s;
    if (mon_en) begin
      a = {inst_req_ready, data_req_ready, mem_req_valid, mem_rsp_ready,
           inst_rsp_valid, data_rsp_valid, busy, owner_data};
      if (exp_ctl_q.size() == 0) check("ctl_queue_underflow", 64'd1, 64'd0);
      else check("ctl", 64'(a), 64'(exp_ctl_q.pop_front()));
      if (mem_req_valid) begin
        if (exp_mem_q.size() == 0) check("mem_req_unexpected", 64'd1, 64'd0);
        else begin
          r = exp_mem_q[0];
          check("mem_addr", 64'(mem_addr), 64'(r.addr));
          check("mem_wen", 64'(mem_wen), 64'(r.wen));
          check("mem_wstrb", 64'(mem_wstrb), 64'(r.wstrb));
          if (r.owner) check("mem_wdata", 64'(mem_wdata), 64'(r.wdata));
          if (mem_req_ready) void'(exp_mem_q.pop_front());
        end
      end
      if ((inst_rsp_valid && inst_rsp_ready) || (data_rsp_valid && data_rsp_ready)) begin
        if (exp_rsp_q.size() == 0) check("rsp_unexpected", 64'd1, 64'd0);
        else begin
          s = exp_rsp_q.pop_front();
          check("rsp_owner", 64'(data_rsp_valid), 64'(s.owner));
          check("rsp_data", 64'(s.owner ? data_rsp_data : inst_rsp_data), 64'(s.data));
        end
      end
    end
  end

  task automatic model_reset();
    exp_ctl_q.delete();
    exp_mem_q.delete();
    exp_rsp_q.delete();
    m_phase    = 0;
    m_owner    = 1'b0;
    inst_taken = 1'b0;
    data_taken = 1'b0;
  endtask

  task automatic run_random(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      drive_random();
      model_cycle();
      mon_en = 1'b1;
    end
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      drive_drain();
      model_cycle();
    end
  endtask

  initial begin
    rst = 1'b1;
    inst_req_addr = '0; inst_req_valid = 1'b0; inst_rsp_ready = 1'b1;
    data_req_addr = '0; data_req_wen = 1'b0; data_req_wdata = '0;
    data_req_wstrb = '0; data_req_valid = 1'b0; data_rsp_ready = 1'b1;
    mem_req_ready = 1'b1; mem_rdata = '0; mem_rsp_valid = 1'b1;

    // Reset state: stray memory response ignored, registers cleared.
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    check("rst_mem_rsp_ready", 64'(mem_rsp_ready), 64'd0);
    check("rst_rsp_valids", 64'({inst_rsp_valid, data_rsp_valid}), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wen", 64'(mem_wen), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_mem_wstrb", 64'(mem_wstrb), 64'd0);
    check("rst_owner", 64'(owner_data), 64'd0);
    // Requester readies follow the idle grant even while in reset.
    inst_req_valid = 1'b1;
    data_req_valid = 1'b1;
    #1;
    check("rst_readies", 64'({inst_req_ready, data_req_ready}), 64'b01);
    inst_req_valid = 1'b0;
    data_req_valid = 1'b0;
    mem_rsp_valid  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    run_random(3000);

    // Store stalled in the request phase, then asynchronous reset.
    @(posedge clk); #1;
    drive_drain();
    data_req_valid = 1'b1; data_req_addr = 32'h200; data_req_wen = 1'b1;
    data_req_wdata = 32'hDEADBEEF; data_req_wstrb = 4'hF; mem_req_ready = 1'b0;
    model_cycle();
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      data_req_valid = 1'b0;
      mem_req_ready  = 1'b0;
      model_cycle();
    end
    @(negedge clk);
    #2;
    mon_en = 1'b0;
    check("pre_rst_in_req", 64'(mem_req_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("arst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_mem_addr", 64'(mem_addr), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check("post_rst_mem_addr", 64'(mem_addr), 64'd0);
    check("post_rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("post_rst_mem_wen", 64'(mem_wen), 64'd0);
    check("post_rst_owner", 64'(owner_data), 64'd0);

    run_random(300);
    @(negedge clk);
    #2;
    mon_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
